// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Memory-wait FSM states and E-stage operand forwarding select encodings.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks outstanding data-memory accesses in M; raises mem_stall while waiting
// and latches a sticky mem_err once a wait exceeds MEM_TIMEOUT cycles.
module hazard_mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req_m,
   input  logic mem_ready,
   output logic mem_stall,
   output logic mem_err
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);

   hz_state_e     state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          mem_err_q, mem_err_d;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_stall  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_req_m && !mem_ready) begin
               mem_stall  = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = CW'(1);
            end
         end
         ST_MEM_WAIT: begin
            // The stalled M instruction keeps its request alive, so only ready matters here.
            if (mem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q < TIMEOUT_C) begin
               mem_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + CW'(1);
            end else begin
               mem_stall = 1'b1;
               state_d   = ST_ERR;
            end
         end
         ST_ERR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
      mem_err_d = mem_err_q | (state_d == ST_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush/forwarding control: memory wait > branch redirect > load-use.
// Perf counters are built only when HAZ_PERF_CNT_EN is defined; otherwise they read zero.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              wr_e,
   input  logic              load_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              wr_m,
   input  logic              load_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              wr_w,
   input  logic              branch_taken_e,
   input  logic              mem_req_m,
   input  logic              mem_ready,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_w,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              mem_err,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       flush_events
);

   localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

   logic mem_stall;
   logic load_use;

   hazard_mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk       (clk),
      .rst       (rst),
      .mem_req_m (mem_req_m),
      .mem_ready (mem_ready),
      .mem_stall (mem_stall),
      .mem_err   (mem_err)
   );

   // A load result is not on the M ALU path, so a load in M can only forward once it reaches W.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (wr_m && !load_m && rd_m != RZ && rd_m == rs) return FWD_MEM;
      else if (wr_w && rd_w != RZ && rd_w == rs)       return FWD_WB;
      else                                            return FWD_RF;
   endfunction

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;
      load_use = load_e && wr_e && (rd_e != RZ) &&
                 ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
      if (!rst) begin
         if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
         fwd_a_e = fwd_sel(rs1_e);
         fwd_b_e = fwd_sel(rs2_e);
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stall_f && stall_cycles_q != 16'hFFFF)
         stall_cycles_d = stall_cycles_q + 16'd1;
      if ((flush_d || flush_e) && flush_events_q != 16'hFFFF)
         flush_events_d = flush_events_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 16'h0000;
         flush_events_q <= 16'h0000;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   assign stall_cycles = 16'h0000;
   assign flush_events = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

   localparam int AW = 3;
   localparam int TMO = 4;

   logic clk, rst;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic use_rs1_d, use_rs2_d, wr_e, load_e, wr_m, load_m, wr_w;
   logic branch_taken_e, mem_req_m, mem_ready;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic [15:0] stall_cycles, flush_events;

   int n_checks = 0;
   int n_err = 0;

   // Model state: cycles the current M access has been blocked, sticky error, event tallies.
   int  m_pend;
   bit  m_err;
   int  m_stalls, m_flushes;
   bit  e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

   hazard_ctrl_unit #(.REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .wr_e(wr_e), .load_e(load_e),
      .rd_m(rd_m), .wr_m(wr_m), .load_m(load_m), .rd_w(rd_w), .wr_w(wr_w),
      .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_fwd(input logic [AW-1:0] rs);
      if (rs == 0) return 0;
      if (wr_m && !load_m && rd_m == rs) return 2;
      if (wr_w && rd_w == rs) return 1;
      return 0;
   endfunction

   task automatic idle_inputs();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {use_rs1_d, use_rs2_d, wr_e, load_e, wr_m, load_m, wr_w} = '0;
      {branch_taken_e, mem_req_m, mem_ready} = '0;
   endtask

   task automatic rand_inputs();
      rs1_d = AW'($urandom_range(0, 3));  rs2_d = AW'($urandom_range(0, 7));
      rs1_e = AW'($urandom_range(0, 3));  rs2_e = AW'($urandom_range(0, 7));
      rd_e  = AW'($urandom_range(0, 3));  rd_m  = AW'($urandom_range(0, 3));
      rd_w  = AW'($urandom_range(0, 3));
      use_rs1_d = 1'($urandom_range(0, 1)); use_rs2_d = 1'($urandom_range(0, 1));
      wr_e = 1'($urandom_range(0, 1)); load_e = 1'($urandom_range(0, 1));
      wr_m = 1'($urandom_range(0, 1)); load_m = 1'($urandom_range(0, 1));
      wr_w = 1'($urandom_range(0, 1));
      branch_taken_e = ($urandom_range(0, 4) == 0);
      mem_req_m = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 1) == 0);
   endtask

   // Evaluate expected outputs from the current inputs and compare everything.
   task automatic eval();
      bit blocked, lu;
      #2;
      blocked = m_err || (!mem_ready && (m_pend > 0 || mem_req_m));
      lu = load_e && wr_e && rd_e != 0 &&
           ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
      if (rst) {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
      else begin
         e_sf = blocked || (!branch_taken_e && lu);
         e_sd = e_sf;
         e_se = blocked;
         e_sm = blocked;
         e_fw = blocked;
         e_fd = !blocked && branch_taken_e;
         e_fe = !blocked && (branch_taken_e || lu);
      end
      chk("stall_f", stall_f, e_sf);
      chk("stall_d", stall_d, e_sd);
      chk("stall_e", stall_e, e_se);
      chk("stall_m", stall_m, e_sm);
      chk("flush_d", flush_d, e_fd);
      chk("flush_e", flush_e, e_fe);
      chk("flush_w", flush_w, e_fw);
      chk("fwd_a_e", fwd_a_e, rst ? 0 : ref_fwd(rs1_e));
      chk("fwd_b_e", fwd_b_e, rst ? 0 : ref_fwd(rs2_e));
      chk("mem_err", mem_err, m_err);
`ifdef HAZ_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("flush_events", flush_events, m_flushes);
`else
      chk("stall_cycles", stall_cycles, 0);
      chk("flush_events", flush_events, 0);
`endif
   endtask

   task automatic tick();
      bit blocked;
      blocked = m_err || (!mem_ready && (m_pend > 0 || mem_req_m));
      if (e_sf && m_stalls < 65535) m_stalls++;
      if ((e_fd || e_fe) && m_flushes < 65535) m_flushes++;
      if (!m_err) begin
         if (blocked) begin
            m_pend++;
            if (m_pend > TMO) m_err = 1;
         end else m_pend = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      eval();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_pend = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
      eval();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #1;
      do_reset();

      // Load-use: one stall cycle, gone once the load leaves E; x0 never hazards.
      load_e = 1; wr_e = 1; rd_e = 3; rs1_d = 3; use_rs1_d = 1;
      eval();
      chk("lu_stall_f", stall_f, 1); chk("lu_flush_e", flush_e, 1);
      tick();
      load_e = 0; wr_e = 0;
      eval(); chk("lu_release", stall_f, 0); tick();
      load_e = 1; wr_e = 1; rd_e = 0; rs1_d = 0;
      eval(); chk("lu_x0", stall_f, 0); tick();

      // Branch beats load-use in the same cycle.
      rd_e = 3; rs1_d = 3; branch_taken_e = 1;
      eval();
      chk("br_flush_d", flush_d, 1); chk("br_flush_e", flush_e, 1); chk("br_stall_f", stall_f, 0);
      tick();
      idle_inputs();

      // Forwarding priority and x0.
      wr_m = 1; rd_m = 2; wr_w = 1; rd_w = 2; rs1_e = 2;
      eval(); chk("fwd_mem", fwd_a_e, 2'b10); tick();
      load_m = 1;
      eval(); chk("fwd_wb", fwd_a_e, 2'b01); tick();
      rs2_e = 0; rd_w = 0;
      eval(); chk("fwd_x0", fwd_b_e, 2'b00); tick();

      // Memory wait of three cycles then two branch flushes, starting from fresh counters.
      idle_inputs();
      do_reset();
      mem_req_m = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         eval(); chk("mw_stall", stall_m, 1); tick();
      end
      mem_ready = 1;
      eval(); chk("mw_ready", stall_f, 0); tick();
      idle_inputs(); branch_taken_e = 1;
      step(); step();
      branch_taken_e = 0;
      eval();
      chk("mw_err", mem_err, 0);
`ifdef HAZ_PERF_CNT_EN
      chk("perf_stall", stall_cycles, 3); chk("perf_flush", flush_events, 2);
`else
      chk("perf_stall_off", stall_cycles, 0); chk("perf_flush_off", flush_events, 0);
`endif
      tick();

      // Timeout: five blocked cycles then sticky error until reset.
      do_reset();
      mem_req_m = 1; mem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         eval(); chk("to_err_low", mem_err, 0); tick();
      end
      mem_req_m = 0; mem_ready = 1;
      eval(); chk("to_err", mem_err, 1); chk("to_stuck", stall_f, 1); tick();
      step();
      do_reset();
      eval(); chk("to_cleared", stall_f, 0); tick();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         rand_inputs();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
